// File: rtl/lfsr_pkg.sv
//------------------------------------------------------------------------------
// Module  : lfsr_pkg
// Purpose : Shared constants for the lfsr_gen block: feedback mode selectors,
//           controller state encoding and known maximal-length tap masks.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package lfsr_pkg;

  // Feedback structure selectors
  localparam int MODE_FIB = 0;  // shift left, parity of taps enters the LSB
  localparam int MODE_GAL = 1;  // shift right, mask XORed in when LSB is set

  // Controller state encoding
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Maximal-length tap masks (bit i set => state[i] is a tap)
  localparam logic [7:0]  TAPS_8  = 8'hB8;
  localparam logic [15:0] TAPS_16 = 16'hD008;
  localparam logic [31:0] TAPS_32 = 32'h8020_0003;

endpackage : lfsr_pkg

`default_nettype wire

// File: rtl/lfsr_next.sv
//------------------------------------------------------------------------------
// Module  : lfsr_next
// Purpose : Combinational LFSR successor function, Fibonacci or Galois form.
// Ports   : i_state [WIDTH] - current register value
//           o_next  [WIDTH] - value after exactly one step
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module lfsr_next
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = 16,
  parameter int               MODE  = MODE_FIB,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(TAPS_16)
) (
  input  logic [WIDTH-1:0] i_state,
  output logic [WIDTH-1:0] o_next
);

  generate
    if (MODE == MODE_GAL) begin : g_gal
      assign o_next = (i_state >> 1) ^ (i_state[0] ? TAPS : '0);
    end else begin : g_fib
      logic w_fb;
      assign w_fb   = ^(i_state & TAPS);
      assign o_next = {i_state[WIDTH-2:0], w_fb};
    end
  endgenerate

endmodule : lfsr_next

`default_nettype wire

// File: rtl/lfsr_gen.sv
//------------------------------------------------------------------------------
// Module  : lfsr_gen
// Purpose : Parametrised LFSR pseudo-random word source with seed-load
//           handshake, valid/ready output stream, pause control and
//           all-zero seed substitution.
// Optional: define LFSR_PERIOD_EN to add the period counter
//           (o_period_wrap / o_period_len); otherwise both read as zero.
// Ports   : clk            - rising-edge clock
//           rst_n          - asynchronous active-low reset
//           i_seed_valid   - seed offer
//           o_seed_ready   - seed taken when i_seed_valid & o_seed_ready
//           i_seed [WIDTH] - seed value
//           i_en           - 1 = run, 0 = pause
//           o_out_valid    - o_state holds a valid word
//           i_out_ready    - consumer takes the word
//           o_state[WIDTH] - current LFSR state / output word
//           o_zero_fix     - pulse: zero seed replaced by DEFAULT_SEED
//           o_period_wrap  - pulse: state returned to the loaded seed
//           o_period_len   - advances in the last completed period
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module lfsr_gen
  import lfsr_pkg::*;
#(
  parameter int               WIDTH        = 16,
  parameter int               MODE         = MODE_FIB,
  parameter logic [WIDTH-1:0] TAPS         = WIDTH'(TAPS_16),
  parameter logic [WIDTH-1:0] DEFAULT_SEED = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_seed_valid,
  output logic             o_seed_ready,
  input  logic [WIDTH-1:0] i_seed,
  input  logic             i_en,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_state,
  output logic             o_zero_fix,
  output logic             o_period_wrap,
  output logic [WIDTH-1:0] o_period_len
);

  logic [0:0]       r_fsm;
  logic [WIDTH-1:0] r_state;
  logic             r_zero_fix;

  logic [WIDTH-1:0] w_next;
  logic             w_load;
  logic             w_advance;
  logic             w_seed_zero;
  logic [WIDTH-1:0] w_seed_fixed;

  lfsr_next #(
    .WIDTH (WIDTH),
    .MODE  (MODE),
    .TAPS  (TAPS)
  ) u_next (
    .i_state (r_state),
    .o_next  (w_next)
  );

  // A seed can only be taken while the generator is not producing words,
  // so a load and an advance are never requested in the same cycle.
  assign o_seed_ready = (r_fsm == ST_IDLE) | ~i_en;
  assign w_load       = i_seed_valid & o_seed_ready;
  assign w_advance    = (r_fsm == ST_RUN) & i_en & i_out_ready & ~w_load;
  assign w_seed_zero  = (i_seed == '0);
  assign w_seed_fixed = w_seed_zero ? DEFAULT_SEED : i_seed;

  assign o_out_valid  = (r_fsm == ST_RUN);
  assign o_state      = r_state;
  assign o_zero_fix   = r_zero_fix;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm      <= ST_IDLE;
      r_state    <= DEFAULT_SEED;
      r_zero_fix <= 1'b0;
    end else begin
      r_zero_fix <= w_load & w_seed_zero;
      if (w_load) begin
        r_state <= w_seed_fixed;
        r_fsm   <= ST_RUN;
      end else if (w_advance) begin
        r_state <= w_next;
      end else if ((r_fsm == ST_IDLE) && i_en) begin
        // Start from the reset seed without stepping.
        r_fsm <= ST_RUN;
      end
    end
  end

`ifdef LFSR_PERIOD_EN
  logic [WIDTH-1:0] r_seed_copy;
  logic [WIDTH-1:0] r_count;
  logic             r_wrap;
  logic [WIDTH-1:0] r_len;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seed_copy <= DEFAULT_SEED;
      r_count     <= '0;
      r_wrap      <= 1'b0;
      r_len       <= '0;
    end else begin
      r_wrap <= 1'b0;
      if (w_load) begin
        r_seed_copy <= w_seed_fixed;
        r_count     <= '0;
      end else if (w_advance) begin
        if (w_next == r_seed_copy) begin
          r_wrap  <= 1'b1;
          r_len   <= r_count + WIDTH'(1);
          r_count <= '0;
        end else if (r_count != '1) begin
          // Saturate silently when no wrap has been seen yet.
          r_count <= r_count + WIDTH'(1);
        end
      end
    end
  end

  assign o_period_wrap = r_wrap;
  assign o_period_len  = r_len;
`else
  assign o_period_wrap = 1'b0;
  assign o_period_len  = '0;
`endif

endmodule : lfsr_gen

`default_nettype wire

// File: tb/tb_lfsr_gen.sv
//------------------------------------------------------------------------------
// Module  : tb_lfsr_gen
// Purpose : Self-checking bench for lfsr_gen. A Fibonacci (taps D008) and a
//           Galois (taps B400) instance share one stimulus stream; each is
//           compared every cycle against a behavioural model, plus literal
//           expectations for known sequence points.
// Optional: LFSR_PERIOD_EN enables the full-period check.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_lfsr_gen;

  localparam logic [15:0] TAPS_F = 16'hD008;
  localparam logic [15:0] TAPS_G = 16'hB400;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sv;
  logic [15:0] seed;
  logic        en;
  logic        ordy;

  logic        d_sready [2];
  logic        d_valid  [2];
  logic [15:0] d_state  [2];
  logic        d_zf     [2];
  logic        d_wrap   [2];
  logic [15:0] d_len    [2];

  int n_total = 0;
  int n_bad   = 0;
  bit chk_on  = 1'b0;

  always #5 clk = ~clk;

  lfsr_gen #(.WIDTH(16), .MODE(0), .TAPS(TAPS_F), .DEFAULT_SEED(16'h0001)) u_fib (
    .clk(clk), .rst_n(rst_n), .i_seed_valid(sv), .o_seed_ready(d_sready[0]),
    .i_seed(seed), .i_en(en), .o_out_valid(d_valid[0]), .i_out_ready(ordy),
    .o_state(d_state[0]), .o_zero_fix(d_zf[0]), .o_period_wrap(d_wrap[0]),
    .o_period_len(d_len[0]));

  lfsr_gen #(.WIDTH(16), .MODE(1), .TAPS(TAPS_G), .DEFAULT_SEED(16'h0001)) u_gal (
    .clk(clk), .rst_n(rst_n), .i_seed_valid(sv), .o_seed_ready(d_sready[1]),
    .i_seed(seed), .i_en(en), .o_out_valid(d_valid[1]), .i_out_ready(ordy),
    .o_state(d_state[1]), .o_zero_fix(d_zf[1]), .o_period_wrap(d_wrap[1]),
    .o_period_len(d_len[1]));

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  // Reference step: Fibonacci takes the parity of the tapped bits into the
  // LSB of a left shift; Galois XORs the mask into a right shift on LSB=1.
  function automatic logic [15:0] step(input int k, input logic [15:0] s);
    if (k == 0) return {s[14:0], 1'($countones(s & TAPS_F) % 2)};
    else        return (s >> 1) ^ (s[0] ? TAPS_G : 16'h0000);
  endfunction

  // ---------------- behavioural model ----------------
  bit          m_run  [2];
  logic [15:0] m_state[2];
  bit          m_zf   [2];
  logic [15:0] m_cnt  [2];
  logic [15:0] m_copy [2];
  bit          m_wrap [2];
  logic [15:0] m_len  [2];

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_run[k] = 0; m_state[k] = 16'h0001; m_zf[k] = 0;
        m_cnt[k] = 0; m_copy[k] = 16'h0001; m_wrap[k] = 0; m_len[k] = 0;
      end else begin
        bit          acc;
        bit          adv;
        logic [15:0] nx;
        acc = sv && (!m_run[k] || !en);
        adv = m_run[k] && en && ordy && !acc;
        m_zf[k]   = acc && (seed == 16'h0000);
        m_wrap[k] = 0;
        if (acc) begin
          m_state[k] = (seed == 16'h0000) ? 16'h0001 : seed;
          m_copy[k]  = m_state[k];
          m_cnt[k]   = 0;
          m_run[k]   = 1;
        end else if (adv) begin
          nx = step(k, m_state[k]);
          if (nx == m_copy[k]) begin
            m_wrap[k] = 1; m_len[k] = m_cnt[k] + 16'd1; m_cnt[k] = 0;
          end else if (m_cnt[k] != 16'hFFFF) begin
            m_cnt[k] = m_cnt[k] + 16'd1;
          end
          m_state[k] = nx;
        end else if (en) begin
          m_run[k] = 1;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_on) begin
      for (int k = 0; k < 2; k++) begin
        check($sformatf("m%0d_state", k),  d_state[k],  m_state[k]);
        check($sformatf("m%0d_valid", k),  d_valid[k],  m_run[k]);
        check($sformatf("m%0d_sready", k), d_sready[k], (!m_run[k] || !en));
        check($sformatf("m%0d_zfix", k),   d_zf[k],     m_zf[k]);
`ifdef LFSR_PERIOD_EN
        check($sformatf("m%0d_wrap", k),   d_wrap[k],   m_wrap[k]);
        check($sformatf("m%0d_len", k),    d_len[k],    m_len[k]);
`else
        check($sformatf("m%0d_wrap", k),   d_wrap[k],   1'b0);
        check($sformatf("m%0d_len", k),    d_len[k],    16'h0000);
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Watchdog so the bench always ends.
  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [15:0] hold_f;
    logic [15:0] hold_g;
    int          n;

    rst_n = 1'b0; sv = 1'b0; seed = 16'h0000; en = 1'b0; ordy = 1'b0;
    #23 rst_n = 1'b1;
    chk_on = 1'b1;

    // Reset state
    tick();
    @(negedge clk);
    check("rst_state_f", d_state[0], 16'h0001);
    check("rst_valid_f", d_valid[0], 1'b0);
    check("rst_sready_f", d_sready[0], 1'b1);
    check("rst_zf_g", d_zf[1], 1'b0);

    // Seed load in IDLE, then first step
    tick();
    sv = 1'b1; seed = 16'hACE1; en = 1'b0; ordy = 1'b1;
    tick();
    sv = 1'b0; en = 1'b1;
    @(negedge clk);
    check("load_state_f", d_state[0], 16'hACE1);
    check("load_state_g", d_state[1], 16'hACE1);
    check("load_valid_f", d_valid[0], 1'b1);
    check("run_sready_f", d_sready[0], 1'b0);
    tick();
    @(negedge clk);
    check("step1_f", d_state[0], 16'h59C3);
    check("step1_g", d_state[1], 16'hE270);
    repeat (1000) tick();

    // Backpressure: word held for 5 cycles, then exactly one advance
    ordy = 1'b0;
    hold_f = d_state[0];
    hold_g = d_state[1];
    repeat (5) tick();
    check("bp_hold_f", d_state[0], hold_f);
    check("bp_hold_g", d_state[1], hold_g);
    check("bp_valid_f", d_valid[0], 1'b1);
    ordy = 1'b1;
    tick();
    check("bp_resume_f", d_state[0], step(0, hold_f));
    check("bp_resume_g", d_state[1], step(1, hold_g));

    // Seed offered while running with en=1 must be refused
    sv = 1'b1; seed = 16'h1234;
    #1 check("run_en_sready_f", d_sready[0], 1'b0);
    tick();
    sv = 1'b0;

    // Mixed pause / backpressure / reload traffic, some zero seeds
    for (int i = 0; i < 300; i++) begin
      en   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 3) != 0);
      sv   = ($urandom_range(0, 7) == 0);
      seed = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
      tick();
    end
    sv = 1'b0;

    // Zero seed in IDLE
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    tick();
    sv = 1'b1; seed = 16'h0000; en = 1'b0;
    tick();
    sv = 1'b0;
    @(negedge clk);
    check("zseed_state_f", d_state[0], 16'h0001);
    check("zseed_zf_f", d_zf[0], 1'b1);
    check("zseed_zf_g", d_zf[1], 1'b1);
    tick();
    @(negedge clk);
    check("zseed_zf_gone_f", d_zf[0], 1'b0);

    // Asynchronous reset between edges while running
    en = 1'b1; ordy = 1'b1;
    repeat (10) tick();
    #3 rst_n = 1'b0;
    #1;
    check("arst_state_f", d_state[0], 16'h0001);
    check("arst_state_g", d_state[1], 16'h0001);
    check("arst_valid_f", d_valid[0], 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("arst_run_state_f", d_state[0], 16'h0001);
    check("arst_run_valid_f", d_valid[0], 1'b1);
    @(negedge clk);
    check("arst_step_f", d_state[0], 16'h0002);
    check("arst_step_g", d_state[1], 16'hB400);

`ifdef LFSR_PERIOD_EN
    // Full period from ACE1
    tick();
    sv = 1'b1; seed = 16'hACE1; en = 1'b0;
    tick();
    sv = 1'b0; en = 1'b1;
    n = 0;
    while (n < 70000) begin
      @(negedge clk);
      n++;
      if (d_wrap[0] === 1'b1) break;
    end
    check("period_advances_f", n, 65535);
    check("period_len_f", d_len[0], 16'hFFFF);
`else
    n = 0;
    repeat (20) tick();
    check("noperiod_len_f", d_len[0], 16'h0000);
    check("noperiod_wrap_g", d_wrap[1], 1'b0);
`endif

    tick();
    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule : tb_lfsr_gen

`default_nettype wire
